protocol_controller_mep: RTL
============================

Name: protocol_controller_mep

Overview:
- Next-generation USB endpoint protocol controller serving NUM_EP endpoints.
- Adds over the single-endpoint controller: per-endpoint DATA0/DATA1 toggle tracking, duplicate-packet detection, per-endpoint STALL, handshake timeout, and bounded IN retry with buffer replay.
- Sits between USB RX/TX, the AHB-Lite slave and the data buffer.

Parameters:
- NUM_EP, 4, number of endpoints (1..16); EP_W = max(1, clog2(NUM_EP)).
- TIMEOUT_CYCLES, 1200, clk cycles to wait for a host DATA/ACK before timing out.
- MAX_RETRY, 3, NAK/timeout retries allowed per IN transfer.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- rx_packet  in  3  RX PID: 000 IDLE/EOP, 001 DATA, 010 OUT, 011 IN, 100 ACK, 101 NAK, 110 BAD.
- rx_endpoint  in  4  endpoint number, valid with OUT/IN.
- rx_data_odd  in  1  received data PID is DATA1; valid with DATA.
- tx_done  in  1  TX finished current packet (1-cycle pulse).
- buffer_reserved  in  1  AHB has loaded/is loading IN data.
- tx_packet_data_size  in  7  bytes AHB intends to send.
- buffer_occupancy  in  7  bytes held in data buffer.
- ep_stall  in  NUM_EP  per-endpoint halt, from AHB registers.
- rx_data_ready, rx_transfer_active, rx_error, tx_transfer_active, tx_error  out  1 each  status to AHB.
- clear  out  1  flush data buffer (1-cycle pulse).
- replay  out  1  rewind buffer read pointer for retransmit (1-cycle pulse).
- tx_packet  out  3  to TX: 000 IDLE, 001 DATA0, 010 DATA1, 011 ACK, 100 NAK, 101 STALL.
- d_mode  out  1  1 = TX driving bus.
- active_ep  out  EP_W  endpoint of current transaction.

Behaviour:
- All outputs registered, decoded from next state; asserted in the same cycle as the state entered.
- Reset: all outputs 0, toggles all 0 (DATA0), retry_cnt 0, timer 0, state IDLE.
- Tokens with rx_endpoint >= NUM_EP are ignored; state stays IDLE, no response.
- IDLE:
  - OUT: latch ep; clear rx_error, tx_error; go RX_WAIT.
  - IN, ep_stall[ep]: HS(STALL).
  - IN, buffer_reserved and occupancy == size: TX_SEND.
  - Any other IN: HS(NAK), rx_error=1.
  - BAD: HS(NAK).
- RX_WAIT (rx_transfer_active=1):
  - DATA: RX_DATA.
  - BAD: clear, HS(NAK), rx_error=1.
  - Timer reaches TIMEOUT_CYCLES: rx_error=1, IDLE.
- RX_DATA (rx_transfer_active=1), leaves on EOP (IDLE):
  - ep stalled: clear, HS(STALL).
  - rx_data_odd != toggle[ep] (duplicate): clear, HS(ACK); toggle unchanged; no rx_data_ready.
  - Match: toggle[ep] flips, rx_data_ready=1, HS(ACK), then DRAIN.
  - BAD before EOP: clear, HS(NAK), rx_error=1.
- HS(x): one cycle with tx_packet=x, d_mode=1, tx_transfer_active=1; then HS_WAIT until tx_done; then DRAIN if pending data, else IDLE.
- DRAIN: rx_data_ready held high until occupancy==0, then IDLE. OUT/IN arriving in DRAIN: HS(NAK) with rx_error=1, then return to DRAIN.
- TX_SEND: one cycle tx_packet = toggle[ep] ? DATA1 : DATA0, then TX_WAIT_DONE (d_mode=1) until tx_done, then TX_WAIT_ACK.
- TX_WAIT_ACK:
  - ACK: toggle[ep] flips, clear, retry_cnt=0, IDLE.
  - NAK or timeout, retry_cnt < MAX_RETRY: retry_cnt++, replay pulse, TX_RETRY.
  - NAK or timeout, retry limit reached: tx_error=1, clear, retry_cnt=0, IDLE.
- TX_RETRY: IN on same ep: TX_SEND with same toggle. OUT, or IN on another ep: HS(NAK).
- Timer: zeroed on entry to RX_WAIT/TX_WAIT_ACK; counts only in those states; saturates.
- rx_error and tx_error are sticky until the next accepted OUT token or AHB transfer (buffer_reserved rising in IDLE).
- Simultaneous ep_stall change mid-transaction: sampled only at the decision points above.
- Reset mid-operation: immediate return to reset values; no clear or replay issued.

Test Plan:
- OUT ep1, DATA0, EOP -> ACK on tx_packet=011, rx_data_ready=1, toggle[1]=1; occupancy to 0 -> IDLE, rx_data_ready=0.
- Repeat OUT ep1 with DATA0 (duplicate) -> clear pulse, ACK sent, rx_data_ready stays 0, toggle[1] stays 1.
- buffer_reserved, size=occupancy=8, IN ep2 -> tx_packet=001 (DATA0); tx_done, ACK -> clear pulse, toggle[2]=1; next IN sends 010 (DATA1).
- IN ep0 with host NAK 4 times, MAX_RETRY=3 -> 3 replay pulses, DATA0 resent each time; 4th NAK -> tx_error=1, clear.
- ep_stall=4'b1000, IN ep3 -> tx_packet=101 (STALL), no data sent; IN ep7 with NUM_EP=4 -> no response.
- OUT ep0 with no DATA for 1200 cycles -> rx_error=1, IDLE; n_rst low during TX_WAIT_DONE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/protocol_controller_mep.sv
// USB multi-endpoint protocol controller: token/data/handshake sequencing, DATA0/1 toggles, STALL, timeout, IN retry.
// Latency: outputs registered from next state, so they change on the same edge the state is entered.
// Backpressure: waits on tx_done for every transmitted packet; DRAIN holds rx_data_ready until the buffer empties.
module protocol_controller_mep #(
    parameter int NUM_EP         = 4,
    parameter int TIMEOUT_CYCLES = 1200,
    parameter int MAX_RETRY      = 3,
    localparam int EP_W          = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [2:0]        rx_packet,
    input  logic [3:0]        rx_endpoint,
    input  logic              rx_data_odd,
    input  logic              tx_done,
    input  logic              buffer_reserved,
    input  logic [6:0]        tx_packet_data_size,
    input  logic [6:0]        buffer_occupancy,
    input  logic [NUM_EP-1:0] ep_stall,
    output logic              rx_data_ready,
    output logic              rx_transfer_active,
    output logic              rx_error,
    output logic              tx_transfer_active,
    output logic              tx_error,
    output logic              clear,
    output logic              replay,
    output logic [2:0]        tx_packet,
    output logic              d_mode,
    output logic [EP_W-1:0]   active_ep
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [4:0] NUM_EP_L = 5'(NUM_EP);

    localparam logic [2:0] RX_EOP  = 3'b000;
    localparam logic [2:0] RX_DATA = 3'b001;
    localparam logic [2:0] RX_OUT  = 3'b010;
    localparam logic [2:0] RX_IN   = 3'b011;
    localparam logic [2:0] RX_ACK  = 3'b100;
    localparam logic [2:0] RX_NAK  = 3'b101;
    localparam logic [2:0] RX_BAD  = 3'b110;

    localparam logic [2:0] TX_IDLE  = 3'b000;
    localparam logic [2:0] TX_DATA0 = 3'b001;
    localparam logic [2:0] TX_DATA1 = 3'b010;
    localparam logic [2:0] TX_ACK   = 3'b011;
    localparam logic [2:0] TX_NAK   = 3'b100;
    localparam logic [2:0] TX_STALL = 3'b101;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RX_WAIT,
        ST_RX_DATA,
        ST_HS,
        ST_HS_WAIT,
        ST_DRAIN,
        ST_TX_SEND,
        ST_TX_WAIT_DONE,
        ST_TX_WAIT_ACK,
        ST_TX_RETRY
    } state_t;

    state_t             state, state_nxt;
    logic [NUM_EP-1:0]  toggle, toggle_nxt;
    logic [RTY_W-1:0]   retry_cnt, retry_nxt;
    logic [TMR_W-1:0]   timer;
    logic               data_odd_q, odd_nxt;
    logic               br_q;

    logic [EP_W-1:0]    ep_nxt;
    logic [2:0]         tx_pkt_nxt;
    logic               clear_nxt, replay_nxt, rx_err_nxt, tx_err_nxt, rdy_nxt;
    logic               d_mode_nxt, tx_act_nxt, rx_act_nxt;

    logic               tok_valid, is_out, is_in, br_rise, timeout;
    logic [EP_W-1:0]    tok_ep;

    // Tokens addressed beyond the implemented endpoints are treated as absent.
    assign tok_valid = ({1'b0, rx_endpoint} < NUM_EP_L);
    assign tok_ep    = rx_endpoint[EP_W-1:0];
    assign is_out    = (rx_packet == RX_OUT) && tok_valid;
    assign is_in     = (rx_packet == RX_IN) && tok_valid;
    assign br_rise   = buffer_reserved && !br_q;
    assign timeout   = (timer == TMR_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_nxt  = state;
        ep_nxt     = active_ep;
        tx_pkt_nxt = TX_IDLE;
        clear_nxt  = 1'b0;
        replay_nxt = 1'b0;
        rx_err_nxt = rx_error;
        tx_err_nxt = tx_error;
        rdy_nxt    = rx_data_ready;
        toggle_nxt = toggle;
        retry_nxt  = retry_cnt;
        odd_nxt    = data_odd_q;

        case (state)
            ST_IDLE: begin
                if (br_rise) begin
                    rx_err_nxt = 1'b0;
                    tx_err_nxt = 1'b0;
                end
                if (is_out) begin
                    ep_nxt     = tok_ep;
                    rx_err_nxt = 1'b0;
                    tx_err_nxt = 1'b0;
                    state_nxt  = ST_RX_WAIT;
                end else if (is_in) begin
                    ep_nxt = tok_ep;
                    if (ep_stall[tok_ep]) begin
                        state_nxt  = ST_HS;
                        tx_pkt_nxt = TX_STALL;
                    end else if (buffer_reserved && (buffer_occupancy == tx_packet_data_size)) begin
                        state_nxt  = ST_TX_SEND;
                        tx_pkt_nxt = toggle[tok_ep] ? TX_DATA1 : TX_DATA0;
                    end else begin
                        state_nxt  = ST_HS;
                        tx_pkt_nxt = TX_NAK;
                        rx_err_nxt = 1'b1;
                    end
                end else if (rx_packet == RX_BAD) begin
                    state_nxt  = ST_HS;
                    tx_pkt_nxt = TX_NAK;
                end
            end

            ST_RX_WAIT: begin
                if (rx_packet == RX_DATA) begin
                    odd_nxt   = rx_data_odd;
                    state_nxt = ST_RX_DATA;
                end else if (rx_packet == RX_BAD) begin
                    clear_nxt  = 1'b1;
                    state_nxt  = ST_HS;
                    tx_pkt_nxt = TX_NAK;
                    rx_err_nxt = 1'b1;
                end else if (timeout) begin
                    rx_err_nxt = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end

            ST_RX_DATA: begin
                if (rx_packet == RX_BAD) begin
                    clear_nxt  = 1'b1;
                    state_nxt  = ST_HS;
                    tx_pkt_nxt = TX_NAK;
                    rx_err_nxt = 1'b1;
                end else if (rx_packet == RX_EOP) begin
                    state_nxt = ST_HS;
                    if (ep_stall[active_ep]) begin
                        clear_nxt  = 1'b1;
                        tx_pkt_nxt = TX_STALL;
                    end else if (data_odd_q != toggle[active_ep]) begin
                        // Host missed our last ACK and resent: acknowledge, discard.
                        clear_nxt  = 1'b1;
                        tx_pkt_nxt = TX_ACK;
                    end else begin
                        toggle_nxt[active_ep] = ~toggle[active_ep];
                        rdy_nxt    = 1'b1;
                        tx_pkt_nxt = TX_ACK;
                    end
                end
            end

            ST_HS: state_nxt = ST_HS_WAIT;

            ST_HS_WAIT: begin
                if (tx_done) state_nxt = rx_data_ready ? ST_DRAIN : ST_IDLE;
            end

            ST_DRAIN: begin
                if (is_out || is_in) begin
                    state_nxt  = ST_HS;
                    tx_pkt_nxt = TX_NAK;
                    rx_err_nxt = 1'b1;
                end else if (buffer_occupancy == 7'd0) begin
                    rdy_nxt   = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end

            ST_TX_SEND: state_nxt = ST_TX_WAIT_DONE;

            ST_TX_WAIT_DONE: begin
                if (tx_done) state_nxt = ST_TX_WAIT_ACK;
            end

            ST_TX_WAIT_ACK: begin
                if (rx_packet == RX_ACK) begin
                    toggle_nxt[active_ep] = ~toggle[active_ep];
                    clear_nxt = 1'b1;
                    retry_nxt = '0;
                    state_nxt = ST_IDLE;
                end else if ((rx_packet == RX_NAK) || timeout) begin
                    if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                        retry_nxt  = retry_cnt + RTY_W'(1);
                        replay_nxt = 1'b1;
                        state_nxt  = ST_TX_RETRY;
                    end else begin
                        tx_err_nxt = 1'b1;
                        clear_nxt  = 1'b1;
                        retry_nxt  = '0;
                        state_nxt  = ST_IDLE;
                    end
                end
            end

            ST_TX_RETRY: begin
                if (is_in && (tok_ep == active_ep)) begin
                    state_nxt  = ST_TX_SEND;
                    tx_pkt_nxt = toggle[active_ep] ? TX_DATA1 : TX_DATA0;
                end else if (is_out || is_in) begin
                    // Host moved on; the pending IN transfer is abandoned.
                    retry_nxt  = '0;
                    state_nxt  = ST_HS;
                    tx_pkt_nxt = TX_NAK;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase

        d_mode_nxt = (state_nxt == ST_HS) || (state_nxt == ST_HS_WAIT) ||
                     (state_nxt == ST_TX_SEND) || (state_nxt == ST_TX_WAIT_DONE);
        tx_act_nxt = d_mode_nxt;
        rx_act_nxt = (state_nxt == ST_RX_WAIT) || (state_nxt == ST_RX_DATA);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state              <= ST_IDLE;
            toggle             <= '0;
            retry_cnt          <= '0;
            timer              <= '0;
            data_odd_q         <= 1'b0;
            br_q               <= 1'b0;
            active_ep          <= '0;
            tx_packet          <= TX_IDLE;
            clear              <= 1'b0;
            replay             <= 1'b0;
            rx_error           <= 1'b0;
            tx_error           <= 1'b0;
            rx_data_ready      <= 1'b0;
            d_mode             <= 1'b0;
            tx_transfer_active <= 1'b0;
            rx_transfer_active <= 1'b0;
        end else begin
            state              <= state_nxt;
            toggle             <= toggle_nxt;
            retry_cnt          <= retry_nxt;
            data_odd_q         <= odd_nxt;
            br_q               <= buffer_reserved;
            active_ep          <= ep_nxt;
            tx_packet          <= tx_pkt_nxt;
            clear              <= clear_nxt;
            replay             <= replay_nxt;
            rx_error           <= rx_err_nxt;
            tx_error           <= tx_err_nxt;
            rx_data_ready      <= rdy_nxt;
            d_mode             <= d_mode_nxt;
            tx_transfer_active <= tx_act_nxt;
            rx_transfer_active <= rx_act_nxt;
            // Timer restarts on entry to a wait state and saturates at the limit.
            if (((state_nxt == ST_RX_WAIT) || (state_nxt == ST_TX_WAIT_ACK)) && (state_nxt != state))
                timer <= '0;
            else if (((state == ST_RX_WAIT) || (state == ST_TX_WAIT_ACK)) && !timeout)
                timer <= timer + TMR_W'(1);
        end
    end

endmodule
